gpio_stim_seq: RTL and testbench
================================

Name: gpio_stim_seq

Overview:
- Synthesizable, programmable GPIO stimulus sequencer that drives `gpio_in` of `pulpino_top` in simulation and FPGA emulation.
- Replaces hard-coded per-test wait/drive scripts with a step table loaded at run time.
- Each step waits on a `gpio_out` bit, drives a `gpio_in` bit, delays, loops or ends.
- It also flags completion and timeouts, so benches and emulation boards share one stimulus mechanism.

Parameters:
- N_GPIO, 32: width of `gpio_in_o` / `gpio_out_i`; IDX_W = $clog2(N_GPIO).
- DEPTH, 16: number of step-table entries; ADDR_W = $clog2(DEPTH); requires ADDR_W <= DLY_W/2.
- DLY_W, 24: width of the step argument field (delay, timeout, loop data).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- prog_we_i  in  1  step-table write strobe.
- prog_addr_i  in  ADDR_W  step-table write address.
- prog_data_i  in  STEP_W  step word {op[2:0], idx[IDX_W-1:0], val, arg[DLY_W-1:0]}; STEP_W = 4 + IDX_W + DLY_W.
- start_i  in  1  pulse: begin execution at step 0.
- abort_i  in  1  pulse: stop execution.
- gpio_out_i  in  N_GPIO  DUT GPIO outputs, synchronous to clk.
- gpio_in_o  out  N_GPIO  driven stimulus to DUT GPIO inputs.
- busy_o  out  1  sequence running.
- done_o  out  1  sticky: END reached.
- error_o  out  1  sticky: wait timeout or illegal op/nesting.
- pc_o  out  ADDR_W  current step index.

Behaviour:
- Reset values:
  - all outputs 0.
  - state IDLE.
  - loop_active = 0, loop_cnt = 0.
  - step table contents undefined.
- Programming:
  - The write takes effect at the clock edge; it is accepted only when busy_o = 0 and silently ignored otherwise.
  - The table is read combinationally at pc.
- FSM states: IDLE, RUN, WAIT, DELAY, DONE, ERR.
- IDLE/DONE/ERR + start_i:
  - Next cycle: pc = 0, busy_o = 1, state RUN.
  - done_o and error_o clear.
  - loop_active clears.
  - gpio_in_o keeps its value.
- start_i while busy_o = 1 is ignored.
- RUN decodes the step at pc in that cycle. Every step occupies at least one cycle.
- Ops:
  - 0 SET: gpio_in_o[idx] <= val at the end of the decode cycle, then pc+1.
  - 1 WAIT_HI / 2 WAIT_LO:
    - If gpio_out_i[idx] already matches in the decode cycle, advance (1 cycle). Otherwise go to WAIT.
    - WAIT samples every cycle and advances in the cycle the match is seen.
    - If arg != 0 and no match within arg cycles after decode, go to ERR with error_o = 1.
    - arg = 0 means no timeout.
  - 3 DELAY:
    - Occupies exactly max(arg, 1) cycles including the decode cycle, then pc+1.
  - 4 LOOP: target = arg[ADDR_W-1:0], count = arg[DLY_W-1:DLY_W/2].
    - If loop_active = 0: load loop_cnt = count and set loop_active = 1.
    - Then, if the effective count != 0: decrement and jump to target. Otherwise clear loop_active and do pc+1.
    - The body therefore executes count+1 times in total.
    - A LOOP at a different pc while loop_active = 1 goes to ERR (single level only).
  - 5 END: go to DONE; busy_o = 0; done_o = 1.
  - 6, 7 illegal: go to ERR.
- pc reaching DEPTH-1 and advancing behaves as END (no wrap to 0).
- ERR: busy_o = 0, error_o = 1; pc_o holds the faulting step.
- abort_i has priority over everything including start_i in the same cycle:
  - Next cycle: IDLE, busy_o = 0, loop_active = 0.
  - done_o and error_o are unchanged; gpio_in_o is held.
- Asynchronous reset mid-sequence returns all outputs to 0 immediately.
- The idx field is never out of range: IDX_W is exact. When N_GPIO is not a power of 2, idx >= N_GPIO goes to ERR.

Decomposition:
- Package gpio_stim_pkg: op_e enum (OP_SET, OP_WAIT_HI, OP_WAIT_LO, OP_DELAY, OP_LOOP, OP_END), state_e enum, and a packed step_t struct parametrised via localparams matching the defaults.
- No sub-module needed. The step table is an inline flop array.

Test Plan:
- Program [SET 4←1, WAIT_HI 1, SET 7←1, END]; start; raise gpio_out[1] 10 cycles later -> gpio_in[4] = 1 one cycle after start, gpio_in[7] = 1 one cycle after the match, done_o = 1, busy_o = 0.
- DELAY arg = 5 between SET 2←1 and SET 2←0 -> gpio_in[2] high for exactly 6 cycles. DELAY arg = 0 -> high 2 cycles.
- Program [WAIT_HI 8 arg = 20, END] with gpio_out[8] held low -> error_o = 1 exactly 21 cycles after start, pc_o = 0, done_o = 0.
- Shift pattern, all with idx = 3: [SET 3←1, WAIT_HI 4, WAIT_LO 4, LOOP count = 7 target = 1, END] with gpio_out[4] toggling every 4 cycles -> exactly 8 WAIT_HI/WAIT_LO pairs consumed, then done_o.
- abort_i mid-WAIT, with start_i asserted in the same cycle -> IDLE next cycle; gpio_in held; start ignored. A following start restarts at pc = 0.
- prog_we_i while busy, and rst_n asserted mid-DELAY -> table entry unchanged; on reset all outputs 0 asynchronously.

Source files
------------

// File: rtl/gpio_stim_pkg.sv
// Shared types for the GPIO stimulus sequencer: opcodes, FSM states and the
// step-word layout used both by the sequencer and by whoever loads its table.
package gpio_stim_pkg;

  localparam int PKG_N_GPIO = 32;
  localparam int PKG_DEPTH  = 16;
  localparam int PKG_DLY_W  = 24;
  localparam int PKG_IDX_W  = $clog2(PKG_N_GPIO);
  localparam int PKG_ADDR_W = $clog2(PKG_DEPTH);
  localparam int PKG_STEP_W = 4 + PKG_IDX_W + PKG_DLY_W;

  typedef enum logic [2:0] {
    OP_SET     = 3'd0,
    OP_WAIT_HI = 3'd1,
    OP_WAIT_LO = 3'd2,
    OP_DELAY   = 3'd3,
    OP_LOOP    = 3'd4,
    OP_END     = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DELAY,
    S_DONE,
    S_ERR
  } state_e;

  // op is kept as raw bits so that the illegal encodings 6 and 7 stay representable
  typedef struct packed {
    logic [2:0]           op;
    logic [PKG_IDX_W-1:0] idx;
    logic                 val;
    logic [PKG_DLY_W-1:0] arg;
  } step_t;

  function automatic step_t make_step(input logic [2:0]           op,
                                      input logic [PKG_IDX_W-1:0] idx,
                                      input logic                 val,
                                      input logic [PKG_DLY_W-1:0] arg);
    step_t s;
    s.op  = op;
    s.idx = idx;
    s.val = val;
    s.arg = arg;
    return s;
  endfunction

  // LOOP argument: repeat count in the upper half, jump target in the low bits
  function automatic logic [PKG_DLY_W-1:0] loop_arg(input logic [PKG_DLY_W/2-1:0] count,
                                                    input logic [PKG_ADDR_W-1:0]  target);
    logic [PKG_DLY_W-1:0] a;
    a = '0;
    a[PKG_DLY_W-1:PKG_DLY_W/2] = count;
    a[PKG_ADDR_W-1:0]          = target;
    return a;
  endfunction

endpackage

// File: rtl/gpio_stim_seq.sv
// Programmable GPIO stimulus sequencer: executes a run-time loaded step table
// that waits on gpio_out bits, drives gpio_in bits, delays and loops.
module gpio_stim_seq
  import gpio_stim_pkg::*;
#(
  parameter  int N_GPIO = 32,
  parameter  int DEPTH  = 16,
  parameter  int DLY_W  = 24,
  localparam int IDX_W  = $clog2(N_GPIO),
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int STEP_W = 4 + IDX_W + DLY_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [STEP_W-1:0] prog_data_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [N_GPIO-1:0] gpio_out_i,
  output logic [N_GPIO-1:0] gpio_in_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] pc_o
);

  localparam int CNT_W = DLY_W - DLY_W / 2;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [N_GPIO-1:0] gpio_q, gpio_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              loop_active_q, loop_active_d;
  logic [CNT_W-1:0]  loop_cnt_q, loop_cnt_d;
  logic [ADDR_W-1:0] loop_pc_q, loop_pc_d;
  logic [DLY_W-1:0]  cnt_q, cnt_d;

  logic [STEP_W-1:0] mem_q [DEPTH];

  logic [STEP_W-1:0] step;
  logic [2:0]        op;
  logic [IDX_W-1:0]  idx;
  logic              val;
  logic [DLY_W-1:0]  arg;
  logic              idx_ok;
  logic              match;
  logic [DLY_W:0]    cnt_inc;
  logic              cnt_reached;
  logic [CNT_W-1:0]  loop_eff;
  logic [ADDR_W-1:0] loop_target;
  logic              last_pc;
  logic              adv;
  logic              finish;
  logic              fault;

  // The table has no reset: its contents are only meaningful once loaded
  always_ff @(posedge clk) begin
    if (prog_we_i && !busy_q) begin
      mem_q[prog_addr_i] <= prog_data_i;
    end
  end

  assign step        = mem_q[pc_q];
  assign op          = step[STEP_W-1 -: 3];
  assign idx         = step[DLY_W+1 +: IDX_W];
  assign val         = step[DLY_W];
  assign arg         = step[DLY_W-1:0];
  assign idx_ok      = ({1'b0, idx} < (IDX_W+1)'(N_GPIO));
  assign match       = (op == OP_WAIT_LO) ? ~gpio_out_i[idx] : gpio_out_i[idx];
  assign cnt_inc     = {1'b0, cnt_q} + (DLY_W+1)'(1);
  assign cnt_reached = (cnt_inc >= {1'b0, arg});
  assign loop_eff    = loop_active_q ? loop_cnt_q : arg[DLY_W-1:DLY_W/2];
  assign loop_target = arg[ADDR_W-1:0];
  assign last_pc     = (pc_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    gpio_d        = gpio_q;
    busy_d        = busy_q;
    done_d        = done_q;
    error_d       = error_q;
    loop_active_d = loop_active_q;
    loop_cnt_d    = loop_cnt_q;
    loop_pc_d     = loop_pc_q;
    cnt_d         = cnt_q;
    adv           = 1'b0;
    finish        = 1'b0;
    fault         = 1'b0;

    case (state_q)
      S_RUN: begin
        case (op)
          OP_SET: begin
            if (!idx_ok) begin
              fault = 1'b1;
            end else begin
              gpio_d[idx] = val;
              adv         = 1'b1;
            end
          end
          OP_WAIT_HI, OP_WAIT_LO: begin
            // cnt counts sampled cycles; the decode cycle is the first of them
            if (!idx_ok) begin
              fault = 1'b1;
            end else if (match) begin
              adv = 1'b1;
            end else if (arg == DLY_W'(1)) begin
              fault = 1'b1;
            end else begin
              state_d = S_WAIT;
              cnt_d   = DLY_W'(1);
            end
          end
          OP_DELAY: begin
            if (arg <= DLY_W'(1)) begin
              adv = 1'b1;
            end else begin
              state_d = S_DELAY;
              cnt_d   = DLY_W'(1);
            end
          end
          OP_LOOP: begin
            if (loop_active_q && (loop_pc_q != pc_q)) begin
              fault = 1'b1;
            end else if (loop_eff != '0) begin
              loop_active_d = 1'b1;
              loop_pc_d     = pc_q;
              loop_cnt_d    = loop_eff - CNT_W'(1);
              pc_d          = loop_target;
            end else begin
              loop_active_d = 1'b0;
              loop_cnt_d    = '0;
              adv           = 1'b1;
            end
          end
          OP_END: finish = 1'b1;
          default: fault = 1'b1;
        endcase
      end
      S_WAIT: begin
        if (match) begin
          adv = 1'b1;
        end else if ((arg != '0) && cnt_reached) begin
          fault = 1'b1;
        end else begin
          cnt_d = cnt_inc[DLY_W-1:0];
        end
      end
      S_DELAY: begin
        if (cnt_reached) begin
          adv = 1'b1;
        end else begin
          cnt_d = cnt_inc[DLY_W-1:0];
        end
      end
      default: ;
    endcase

    // Stepping past the last entry finishes the sequence instead of wrapping
    if (adv) begin
      if (last_pc) begin
        finish = 1'b1;
      end else begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_RUN;
      end
    end

    if (finish) begin
      state_d = S_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end

    if (fault) begin
      state_d = S_ERR;
      busy_d  = 1'b0;
      error_d = 1'b1;
    end

    if (!busy_q && start_i) begin
      state_d       = S_RUN;
      pc_d          = '0;
      busy_d        = 1'b1;
      done_d        = 1'b0;
      error_d       = 1'b0;
      loop_active_d = 1'b0;
    end

    // Abort wins over everything, freezes the pins and leaves the sticky flags alone
    if (abort_i) begin
      state_d       = S_IDLE;
      pc_d          = pc_q;
      gpio_d        = gpio_q;
      busy_d        = 1'b0;
      done_d        = done_q;
      error_d       = error_q;
      loop_active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      gpio_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      loop_active_q <= 1'b0;
      loop_cnt_q    <= '0;
      loop_pc_q     <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      gpio_q        <= gpio_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      loop_active_q <= loop_active_d;
      loop_cnt_q    <= loop_cnt_d;
      loop_pc_q     <= loop_pc_d;
      cnt_q         <= cnt_d;
    end
  end

  assign gpio_in_o = gpio_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign error_o   = error_q;
  assign pc_o      = pc_q;

endmodule

// File: tb/tb_gpio_stim_seq.sv
// Self-checking bench for gpio_stim_seq: a table of two-step programs plus
// hand-written sequences for waits, delays, loops, abort and reset.
module tb_gpio_stim_seq;
  import gpio_stim_pkg::*;

  localparam int NV = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_we_i = 1'b0;
  logic [3:0]  prog_addr_i = '0;
  logic [32:0] prog_data_i = '0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] gpio_out_i = '0;
  logic [31:0] gpio_in_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [3:0]  pc_o;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  gpio_stim_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_we_i   (prog_we_i),
    .prog_addr_i (prog_addr_i),
    .prog_data_i (prog_data_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .gpio_out_i  (gpio_out_i),
    .gpio_in_o   (gpio_in_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .pc_o        (pc_o)
  );

  typedef struct {
    string       name;
    step_t       s0;
    step_t       s1;
    logic [31:0] gpio_out;
    logic [31:0] exp_gpio;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_error;
    logic [3:0]  exp_pc;
  } vec_t;

  vec_t vecs[NV];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input step_t s);
    prog_we_i   = 1'b1;
    prog_addr_i = addr;
    prog_data_i = s;
    tick();
    prog_we_i   = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_delay_test(input string name, input logic [23:0] dly, input int exp_high);
    int high;
    high = 0;
    do_reset();
    applyStimulus(4'd0, make_step(OP_SET,   5'd2, 1'b1, 24'd0));
    applyStimulus(4'd1, make_step(OP_DELAY, 5'd0, 1'b0, dly));
    applyStimulus(4'd2, make_step(OP_SET,   5'd2, 1'b0, 24'd0));
    applyStimulus(4'd3, make_step(OP_END,   5'd0, 1'b0, 24'd0));
    pulse_start();
    for (int c = 0; c < 40; c++) begin
      if (gpio_in_o[2]) high++;
      tick();
    end
    checkOutput({name, ".high_cycles"}, 32'(high), 32'(exp_high));
    checkOutput({name, ".done"}, 32'(done_o), 32'd1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    step_t end_step;
    int    hi_done;
    int    lo_done;
    logic [3:0] prev_pc;
    bit    finished;

    end_step = make_step(OP_END, 5'd0, 1'b0, 24'd0);

    vecs[0]  = '{"set_bit4",     make_step(OP_SET, 5'd4, 1'b1, 24'd0), end_step,
                 32'h0, 32'h10, 1'b0, 1'b1, 1'b0, 4'd1};
    vecs[1]  = '{"set_bit31",    make_step(OP_SET, 5'd31, 1'b1, 24'd0), end_step,
                 32'h0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 4'd1};
    vecs[2]  = '{"set_clear",    make_step(OP_SET, 5'd2, 1'b1, 24'd0), make_step(OP_SET, 5'd2, 1'b0, 24'd0),
                 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 4'd2};
    vecs[3]  = '{"wait_hi_now",  make_step(OP_WAIT_HI, 5'd5, 1'b0, 24'd0), end_step,
                 32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 4'd1};
    vecs[4]  = '{"wait_lo_now",  make_step(OP_WAIT_LO, 5'd5, 1'b0, 24'd0), end_step,
                 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 4'd1};
    vecs[5]  = '{"wait_hi_to1",  make_step(OP_WAIT_HI, 5'd5, 1'b0, 24'd1), end_step,
                 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[6]  = '{"wait_lo_to3",  make_step(OP_WAIT_LO, 5'd9, 1'b0, 24'd3), end_step,
                 32'h200, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[7]  = '{"illegal6",     make_step(3'd6, 5'd0, 1'b0, 24'd0), end_step,
                 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[8]  = '{"illegal7",     make_step(3'd7, 5'd0, 1'b0, 24'd0), end_step,
                 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[9]  = '{"delay0",       make_step(OP_DELAY, 5'd0, 1'b0, 24'd0), end_step,
                 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 4'd1};
    vecs[10] = '{"loop_zero",    make_step(OP_LOOP, 5'd0, 1'b0, loop_arg(12'd0, 4'd0)), end_step,
                 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 4'd1};
    vecs[11] = '{"end_first",    end_step, make_step(OP_SET, 5'd1, 1'b1, 24'd0),
                 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[12] = '{"nested_loop",  make_step(OP_LOOP, 5'd0, 1'b0, loop_arg(12'd1, 4'd1)),
                 make_step(OP_LOOP, 5'd0, 1'b0, loop_arg(12'd1, 4'd2)),
                 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd1};
    vecs[13] = '{"loop_twice",   make_step(OP_SET, 5'd1, 1'b1, 24'd0),
                 make_step(OP_LOOP, 5'd0, 1'b0, loop_arg(12'd2, 4'd0)),
                 32'h0, 32'h2, 1'b0, 1'b1, 1'b0, 4'd2};
    vecs[14] = '{"wait_forever", make_step(OP_WAIT_HI, 5'd7, 1'b0, 24'd0), end_step,
                 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 4'd0};

    // Reset state, observed while reset is still asserted
    #3;
    checkOutput("reset.gpio",  gpio_in_o, 32'h0);
    checkOutput("reset.busy",  32'(busy_o), 32'd0);
    checkOutput("reset.done",  32'(done_o), 32'd0);
    checkOutput("reset.error", 32'(error_o), 32'd0);
    checkOutput("reset.pc",    32'(pc_o), 32'd0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_reset();
      applyStimulus(4'd0, vecs[i].s0);
      applyStimulus(4'd1, vecs[i].s1);
      applyStimulus(4'd2, end_step);
      gpio_out_i = vecs[i].gpio_out;
      pulse_start();
      repeat (30) tick();
      checkOutput({vecs[i].name, ".gpio"},  gpio_in_o,        vecs[i].exp_gpio);
      checkOutput({vecs[i].name, ".busy"},  32'(busy_o),      32'(vecs[i].exp_busy));
      checkOutput({vecs[i].name, ".done"},  32'(done_o),      32'(vecs[i].exp_done));
      checkOutput({vecs[i].name, ".error"}, 32'(error_o),     32'(vecs[i].exp_error));
      checkOutput({vecs[i].name, ".pc"},    32'(pc_o),        32'(vecs[i].exp_pc));
      gpio_out_i = '0;
    end

    // Every entry a SET: running off the end of the table finishes like END
    do_reset();
    for (int a = 0; a < 16; a++) applyStimulus(4'(a), make_step(OP_SET, 5'(a), 1'b1, 24'd0));
    pulse_start();
    repeat (20) tick();
    checkOutput("table_end.gpio",  gpio_in_o, 32'h0000_FFFF);
    checkOutput("table_end.done",  32'(done_o), 32'd1);
    checkOutput("table_end.busy",  32'(busy_o), 32'd0);
    checkOutput("table_end.pc",    32'(pc_o), 32'd15);

    // SET, WAIT_HI, SET, END with the awaited bit rising later
    do_reset();
    applyStimulus(4'd0, make_step(OP_SET,     5'd4, 1'b1, 24'd0));
    applyStimulus(4'd1, make_step(OP_WAIT_HI, 5'd1, 1'b0, 24'd0));
    applyStimulus(4'd2, make_step(OP_SET,     5'd7, 1'b1, 24'd0));
    applyStimulus(4'd3, end_step);
    pulse_start();
    checkOutput("handshake.busy_start", 32'(busy_o), 32'd1);
    tick();
    checkOutput("handshake.gpio4", gpio_in_o, 32'h10);
    repeat (8) tick();
    checkOutput("handshake.waiting_pc", 32'(pc_o), 32'd1);
    gpio_out_i[1] = 1'b1;
    tick();
    checkOutput("handshake.match_pc", 32'(pc_o), 32'd2);
    checkOutput("handshake.gpio7_not_yet", gpio_in_o, 32'h10);
    tick();
    checkOutput("handshake.gpio7", gpio_in_o, 32'h90);
    tick();
    checkOutput("handshake.done", 32'(done_o), 32'd1);
    checkOutput("handshake.busy_end", 32'(busy_o), 32'd0);
    gpio_out_i = '0;

    run_delay_test("delay5", 24'd5, 6);
    run_delay_test("delay0", 24'd0, 2);

    // Wait timeout: error appears on the 21st edge counted from the start edge
    do_reset();
    applyStimulus(4'd0, make_step(OP_WAIT_HI, 5'd8, 1'b0, 24'd20));
    applyStimulus(4'd1, end_step);
    pulse_start();
    repeat (19) tick();
    checkOutput("timeout.error_early", 32'(error_o), 32'd0);
    tick();
    checkOutput("timeout.error", 32'(error_o), 32'd1);
    checkOutput("timeout.pc",    32'(pc_o), 32'd0);
    checkOutput("timeout.done",  32'(done_o), 32'd0);
    checkOutput("timeout.busy",  32'(busy_o), 32'd0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checkOutput("timeout.error_after_abort", 32'(error_o), 32'd1);

    // Loop over a WAIT_HI/WAIT_LO pair with gpio_out[4] toggling every 4 cycles
    do_reset();
    applyStimulus(4'd0, make_step(OP_SET,     5'd3, 1'b1, 24'd0));
    applyStimulus(4'd1, make_step(OP_WAIT_HI, 5'd4, 1'b0, 24'd0));
    applyStimulus(4'd2, make_step(OP_WAIT_LO, 5'd4, 1'b0, 24'd0));
    applyStimulus(4'd3, make_step(OP_LOOP,    5'd3, 1'b0, loop_arg(12'd7, 4'd1)));
    applyStimulus(4'd4, end_step);
    pulse_start();
    hi_done  = 0;
    lo_done  = 0;
    prev_pc  = pc_o;
    finished = 1'b0;
    for (int c = 0; c < 300 && !finished; c++) begin
      gpio_out_i[4] = ((c / 4) % 2) == 1;
      tick();
      if (pc_o == 4'd2 && prev_pc == 4'd1) hi_done++;
      if (pc_o == 4'd3 && prev_pc == 4'd2) lo_done++;
      prev_pc  = pc_o;
      finished = done_o || error_o;
    end
    checkOutput("loop.hi_waits", 32'(hi_done), 32'd8);
    checkOutput("loop.lo_waits", 32'(lo_done), 32'd8);
    checkOutput("loop.done",     32'(done_o), 32'd1);
    checkOutput("loop.error",    32'(error_o), 32'd0);
    checkOutput("loop.gpio",     gpio_in_o, 32'h8);
    gpio_out_i = '0;

    // Abort during a wait with start in the same cycle
    do_reset();
    applyStimulus(4'd0, make_step(OP_SET,     5'd6, 1'b1, 24'd0));
    applyStimulus(4'd1, make_step(OP_WAIT_HI, 5'd9, 1'b0, 24'd0));
    applyStimulus(4'd2, end_step);
    pulse_start();
    repeat (4) tick();
    checkOutput("abort.pre_busy", 32'(busy_o), 32'd1);
    checkOutput("abort.pre_pc",   32'(pc_o), 32'd1);
    abort_i = 1'b1;
    start_i = 1'b1;
    tick();
    abort_i = 1'b0;
    start_i = 1'b0;
    checkOutput("abort.busy",  32'(busy_o), 32'd0);
    checkOutput("abort.gpio",  gpio_in_o, 32'h40);
    checkOutput("abort.done",  32'(done_o), 32'd0);
    checkOutput("abort.error", 32'(error_o), 32'd0);
    repeat (3) tick();
    checkOutput("abort.still_idle", 32'(busy_o), 32'd0);
    pulse_start();
    checkOutput("restart.busy", 32'(busy_o), 32'd1);
    checkOutput("restart.pc",   32'(pc_o), 32'd0);
    gpio_out_i[9] = 1'b1;
    repeat (5) tick();
    checkOutput("restart.done", 32'(done_o), 32'd1);
    checkOutput("restart.gpio", gpio_in_o, 32'h40);
    gpio_out_i = '0;

    // Write while busy is dropped; reset mid-DELAY clears outputs at once
    do_reset();
    applyStimulus(4'd0, make_step(OP_SET,   5'd0,  1'b1, 24'd0));
    applyStimulus(4'd1, make_step(OP_DELAY, 5'd0,  1'b0, 24'd50));
    applyStimulus(4'd2, make_step(OP_SET,   5'd10, 1'b1, 24'd0));
    applyStimulus(4'd3, end_step);
    pulse_start();
    repeat (5) tick();
    applyStimulus(4'd2, make_step(OP_SET, 5'd11, 1'b1, 24'd0));
    checkOutput("midrun.busy", 32'(busy_o), 32'd1);
    checkOutput("midrun.pc",   32'(pc_o), 32'd1);
    rst_n = 1'b0;
    #2;
    checkOutput("async_reset.gpio",  gpio_in_o, 32'h0);
    checkOutput("async_reset.busy",  32'(busy_o), 32'd0);
    checkOutput("async_reset.pc",    32'(pc_o), 32'd0);
    checkOutput("async_reset.done",  32'(done_o), 32'd0);
    checkOutput("async_reset.error", 32'(error_o), 32'd0);
    tick();
    rst_n = 1'b1;
    pulse_start();
    repeat (60) tick();
    checkOutput("protect.done", 32'(done_o), 32'd1);
    checkOutput("protect.gpio", gpio_in_o, 32'h401);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
